// File: rtl/log_seq_pkg.sv
// Shared definitions for the log_seq sequencer: opcodes, logic-unit function
// selects, FSM state encoding and the format-I instruction layout.
package log_seq_pkg;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_BIT = 4'hB;
  localparam logic [3:0] OP_BIC = 4'hC;
  localparam logic [3:0] OP_BIS = 4'hD;
  localparam logic [3:0] OP_XOR = 4'hE;
  localparam logic [3:0] OP_AND = 4'hF;

  localparam logic [3:0] FS_AND = 4'b0000;
  localparam logic [3:0] FS_BIC = 4'b1000;
  localparam logic [3:0] FS_BIS = 4'b0001;
  localparam logic [3:0] FS_XOR = 4'b0010;
  localparam logic [3:0] FS_MOV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] src;
    logic       ad;
    logic       bw;
    logic [1:0] as_mode;
    logic [3:0] dst;
  } instr_t;

  // Only the logic-class format-I opcodes are executed here; everything else
  // (arithmetic 5..A and non-format-I 0..3) is rejected as illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_MOV, OP_BIT, OP_BIC, OP_BIS, OP_XOR, OP_AND: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] fs_of(input logic [3:0] op);
    case (op)
      OP_BIC:  return FS_BIC;
      OP_BIS:  return FS_BIS;
      OP_XOR:  return FS_XOR;
      OP_MOV:  return FS_MOV;
      default: return FS_AND;
    endcase
  endfunction

  function automatic logic sets_flags(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_BIT) || (op == OP_XOR);
  endfunction

  function automatic logic writes_back(input logic [3:0] op);
    return is_legal_op(op) && (op != OP_BIT);
  endfunction

endpackage

// File: rtl/log_seq_flags.sv
// Status-flag generation for the logic ops: N/Z/C/V from the unit result and
// the operand sign bits, plus whether the op updates the status register.
module log_flags
  import log_seq_pkg::*;
#(
  parameter int SIZE = 16
)
(
  input  logic [SIZE-1:0] result,
  input  logic            src_msb,
  input  logic            dst_msb,
  input  logic [3:0]      op,
  input  logic            bw,
  output logic            n,
  output logic            z,
  output logic            c,
  output logic            v,
  output logic            update
);

  always_comb begin
    n      = bw ? result[7] : result[SIZE-1];
    z      = bw ? (result[7:0] == 8'h00) : (result == '0);
    c      = ~z;
    v      = (op == OP_XOR) && src_msb && dst_msb;
    update = sets_flags(op);
  end

endmodule

// File: rtl/log_seq.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) driving an external logic unit for
// MSP430 format-I logic ops. Define LOG_SEQ_FLAGS_EN to build the N/Z/C/V logic.
module log_seq
  import log_seq_pkg::*;
#(
  parameter int SIZE = 16
)
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [15:0]     INSTR,
  input  logic            INSTR_VALID,
  output logic            INSTR_READY,
  output logic [3:0]      RF_ADDR_A,
  output logic [3:0]      RF_ADDR_B,
  input  logic [SIZE-1:0] RF_DATA_A,
  input  logic [SIZE-1:0] RF_DATA_B,
  output logic [3:0]      FS,
  output logic [SIZE-1:0] SRC_OUT,
  output logic [SIZE-1:0] DST_OUT,
  input  logic [SIZE-1:0] LOG_IN,
  output logic            RF_WE,
  output logic [3:0]      RF_WADDR,
  output logic [SIZE-1:0] RF_WDATA,
  output logic            N,
  output logic            Z,
  output logic            C,
  output logic            V,
  output logic            SR_WE,
  output logic            DONE,
  output logic            ILLEGAL
);

  localparam logic [SIZE-1:0] BYTE_MASK = SIZE'(8'hFF);

  state_t          state, state_next;
  instr_t          in_w;
  logic            illegal_in;
  logic [3:0]      op_q;
  logic            bw_q;
  logic            ill_q;
  logic [3:0]      addr_a, addr_b;
  logic [SIZE-1:0] op_a, op_b, result;
  logic [SIZE-1:0] log_masked;

  assign in_w       = instr_t'(INSTR);
  assign illegal_in = !is_legal_op(in_w.op) || in_w.ad || (in_w.as_mode != 2'b00);
  assign log_masked = bw_q ? (LOG_IN & BYTE_MASK) : LOG_IN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    INSTR_READY = 1'b0;
    FS          = '0;
    RF_WE       = 1'b0;
    DONE        = 1'b0;
    ILLEGAL     = 1'b0;
    case (state)
      IDLE: begin
        INSTR_READY = 1'b1;
        // Illegal words skip the datapath and report straight from WB.
        if (INSTR_VALID) state_next = illegal_in ? WB : READ;
      end
      READ: state_next = EXEC;
      EXEC: begin
        FS         = fs_of(op_q);
        state_next = WB;
      end
      WB: begin
        DONE       = 1'b1;
        ILLEGAL    = ill_q;
        RF_WE      = !ill_q && writes_back(op_q);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q   <= '0;
      bw_q   <= 1'b0;
      ill_q  <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && INSTR_VALID) begin
        op_q   <= in_w.op;
        bw_q   <= in_w.bw;
        ill_q  <= illegal_in;
        addr_a <= in_w.src;
        addr_b <= in_w.dst;
      end
      if (state == READ) begin
        op_a <= bw_q ? (RF_DATA_A & BYTE_MASK) : RF_DATA_A;
        op_b <= bw_q ? (RF_DATA_B & BYTE_MASK) : RF_DATA_B;
      end
      if (state == EXEC) result <= log_masked;
    end
  end

  assign RF_ADDR_A = addr_a;
  assign RF_ADDR_B = addr_b;
  assign SRC_OUT   = op_a;
  assign DST_OUT   = op_b;
  assign RF_WADDR  = addr_b;
  assign RF_WDATA  = result;

`ifdef LOG_SEQ_FLAGS_EN
  logic f_n, f_z, f_c, f_v, f_upd;
  logic src_msb, dst_msb;
  logic n_q, z_q, c_q, v_q;

  assign src_msb = bw_q ? op_a[7] : op_a[SIZE-1];
  assign dst_msb = bw_q ? op_b[7] : op_b[SIZE-1];

  log_flags #(.SIZE(SIZE)) u_flags (
    .result  (log_masked),
    .src_msb (src_msb),
    .dst_msb (dst_msb),
    .op      (op_q),
    .bw      (bw_q),
    .n       (f_n),
    .z       (f_z),
    .c       (f_c),
    .v       (f_v),
    .update  (f_upd)
  );

  // Flags are registered at the end of EXEC so they are already valid while
  // SR_WE is high in WB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state == EXEC && f_upd) begin
      n_q <= f_n;
      z_q <= f_z;
      c_q <= f_c;
      v_q <= f_v;
    end
  end

  assign N     = n_q;
  assign Z     = z_q;
  assign C     = c_q;
  assign V     = v_q;
  assign SR_WE = (state == WB) && !ill_q && f_upd;
`else
  assign N     = 1'b0;
  assign Z     = 1'b0;
  assign C     = 1'b0;
  assign V     = 1'b0;
  assign SR_WE = 1'b0;
`endif

endmodule

// File: tb/tb_log_seq.sv
// Directed bench for log_seq with a register-file and logic-unit model.
module tb_log_seq;
  localparam int SIZE = 16;
`ifdef LOG_SEQ_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic [15:0]     INSTR;
  logic            INSTR_VALID;
  logic            INSTR_READY;
  logic [3:0]      RF_ADDR_A, RF_ADDR_B;
  logic [SIZE-1:0] RF_DATA_A, RF_DATA_B;
  logic [3:0]      FS;
  logic [SIZE-1:0] SRC_OUT, DST_OUT, LOG_IN;
  logic            RF_WE;
  logic [3:0]      RF_WADDR;
  logic [SIZE-1:0] RF_WDATA;
  logic            N, Z, C, V, SR_WE, DONE, ILLEGAL;

  log_seq #(.SIZE(SIZE)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .RF_ADDR_A(RF_ADDR_A), .RF_ADDR_B(RF_ADDR_B),
    .RF_DATA_A(RF_DATA_A), .RF_DATA_B(RF_DATA_B), .FS(FS), .SRC_OUT(SRC_OUT),
    .DST_OUT(DST_OUT), .LOG_IN(LOG_IN), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR),
    .RF_WDATA(RF_WDATA), .N(N), .Z(Z), .C(C), .V(V), .SR_WE(SR_WE),
    .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Register file: combinational read, write port plus a preload port.
  logic [SIZE-1:0] rf [16];
  logic            pl_en;
  logic [3:0]      pl_addr;
  logic [SIZE-1:0] pl_data;

  assign RF_DATA_A = rf[RF_ADDR_A];
  assign RF_DATA_B = rf[RF_ADDR_B];

  always @(posedge CLK) begin
    if (pl_en)      rf[pl_addr]  <= pl_data;
    else if (RF_WE) rf[RF_WADDR] <= RF_WDATA;
  end

  // External logic unit.
  always_comb begin
    case (FS)
      4'b0000: LOG_IN = SRC_OUT & DST_OUT;
      4'b1000: LOG_IN = ~SRC_OUT & DST_OUT;
      4'b0001: LOG_IN = SRC_OUT | DST_OUT;
      4'b0010: LOG_IN = SRC_OUT ^ DST_OUT;
      4'b0011: LOG_IN = SRC_OUT;
      default: LOG_IN = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  int unsigned done_lat, ill_lat;
  logic        saw_we, saw_srwe, saw_ready;
  logic [3:0]  fs_exec, a_read, b_read, flags_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [SIZE-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] w);
    int unsigned guard;
    guard = 0;
    while (INSTR_READY !== 1'b1 && guard < 16) begin
      @(posedge CLK); #1; guard++;
    end
    INSTR = w; INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    done_lat = 0; ill_lat = 0; saw_we = 1'b0; saw_srwe = 1'b0; saw_ready = 1'b0;
    fs_exec = 4'hx; a_read = 4'hx; b_read = 4'hx; flags_s = 4'hx;
    for (int unsigned c = 1; c <= 8; c++) begin
      if (c == 1) begin a_read = RF_ADDR_A; b_read = RF_ADDR_B; end
      if (c == 2) fs_exec = FS;
      if (RF_WE)  saw_we = 1'b1;
      if (SR_WE)  saw_srwe = 1'b1;
      if (ILLEGAL && ill_lat == 0) ill_lat = c;
      if (DONE) begin
        done_lat = c;
        flags_s  = {N, Z, C, V};
        break;
      end
      if (INSTR_READY) saw_ready = 1'b1;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; INSTR = '0; INSTR_VALID = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    chk("rst_ready", INSTR_READY, 1);
    chk("rst_outs", {RF_WE, SR_WE, DONE, ILLEGAL}, 0);
    chk("rst_fs", FS, 0);
    chk("rst_flags", {N, Z, C, V}, 0);
    chk("rst_addr", {RF_ADDR_A, RF_ADDR_B, RF_WADDR}, 0);
    chk("rst_data", {SRC_OUT, RF_WDATA}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // AND word mode
    set_reg(4'd4, 16'h0F0F);
    set_reg(4'd5, 16'h00FF);
    run_instr(16'hF405);
    chk("and_lat", done_lat, 3);
    chk("and_addr", {a_read, b_read}, 8'h45);
    chk("and_fs", fs_exec, 4'b0000);
    chk("and_busy_ready", saw_ready, 0);
    chk("and_we", saw_we, 1);
    chk("and_r5", rf[5], 16'h000F);
    chk("and_flags", flags_s, FL ? 4'b0010 : 4'b0000);
    chk("and_srwe", saw_srwe, FL);

    // BIC byte mode, flags untouched
    set_reg(4'd4, 16'h00F0);
    set_reg(4'd5, 16'h12FF);
    run_instr(16'hC445);
    chk("bic_fs", fs_exec, 4'b1000);
    chk("bic_r5", rf[5], 16'h000F);
    chk("bic_srwe", saw_srwe, 0);
    chk("bic_flags", flags_s, FL ? 4'b0010 : 4'b0000);

    // BIT with zero result: no write
    set_reg(4'd6, 16'h8000);
    set_reg(4'd7, 16'h0001);
    run_instr(16'hB607);
    chk("bit_lat", done_lat, 3);
    chk("bit_we", saw_we, 0);
    chk("bit_r7", rf[7], 16'h0001);
    chk("bit_flags", flags_s, FL ? 4'b0100 : 4'b0000);
    chk("bit_srwe", saw_srwe, FL);

    // XOR with both operands negative
    set_reg(4'd8, 16'h8001);
    set_reg(4'd9, 16'h8000);
    run_instr(16'hE809);
    chk("xor_fs", fs_exec, 4'b0010);
    chk("xor_r9", rf[9], 16'h0001);
    chk("xor_flags", flags_s, FL ? 4'b0011 : 4'b0000);

    // Illegal: ADD opcode, As=01, Ad=1
    run_instr(16'h5405);
    chk("add_lat", done_lat, 1);
    chk("add_ill", ill_lat, 1);
    chk("add_we_srwe", {saw_we, saw_srwe}, 0);
    chk("add_r5", rf[5], 16'h000F);
    chk("add_flags", flags_s, FL ? 4'b0011 : 4'b0000);
    run_instr(16'hF415);
    chk("as_lat", done_lat, 1);
    chk("as_ill", ill_lat, 1);
    chk("as_we_srwe", {saw_we, saw_srwe}, 0);
    run_instr(16'hF485);
    chk("ad_ill", ill_lat, 1);
    chk("ad_we_srwe", {saw_we, saw_srwe}, 0);
    chk("ad_r5", rf[5], 16'h000F);

    // AND.B with src==dst: upper bits cleared, N from bit 7
    set_reg(4'd12, 16'hAB80);
    run_instr(16'hFC4C);
    chk("andb_addr", {a_read, b_read}, 8'hCC);
    chk("andb_r12", rf[12], 16'h0080);
    chk("andb_flags", flags_s, FL ? 4'b1010 : 4'b0000);

    // BIS word mode
    set_reg(4'd1, 16'h00F0);
    set_reg(4'd2, 16'h0F00);
    run_instr(16'hD102);
    chk("bis_fs", fs_exec, 4'b0001);
    chk("bis_r2", rf[2], 16'h0FF0);
    chk("bis_srwe", saw_srwe, 0);
    chk("bis_flags", flags_s, FL ? 4'b1010 : 4'b0000);

    // Reset during EXEC of a MOV
    set_reg(4'd10, 16'h1234);
    set_reg(4'd11, 16'hFFFF);
    INSTR = 16'h4A0B; INSTR_VALID = 1'b1;
    @(posedge CLK); #1;
    INSTR_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("mrst_exec_fs", FS, 4'b0011);
    RST = 1'b1;
    #1;
    chk("mrst_ready", INSTR_READY, 1);
    chk("mrst_outs", {RF_WE, SR_WE, DONE, ILLEGAL}, 0);
    chk("mrst_fs", FS, 0);
    chk("mrst_ops", {SRC_OUT, RF_ADDR_A}, 0);
    chk("mrst_flags", {N, Z, C, V}, 0);
    @(posedge CLK); #1;
    chk("mrst_held", {RF_WE, DONE}, 0);
    RST = 1'b0;
    chk("mrst_release_ready", INSTR_READY, 1);
    @(posedge CLK); #1;
    chk("mrst_no_done", DONE, 0);
    chk("mrst_r11", rf[11], 16'hFFFF);

    run_instr(16'h4A0B);
    chk("mov_lat", done_lat, 3);
    chk("mov_fs", fs_exec, 4'b0011);
    chk("mov_r11", rf[11], 16'h1234);
    chk("mov_srwe", saw_srwe, 0);
    chk("mov_flags", flags_s, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
